// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pkg
//  Purpose  : Shared constants for the fetch PC unit: instruction size,
//             FSM state encoding and the redirect alignment mask.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Bytes per instruction word; the sequential pc step.
    localparam int INSTR_BYTES = 4;

    // Low address bits that must be zero in any fetch address.
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    // Fetch FSM encoding.
    localparam logic [0:0] ST_RUN  = 1'b0;  // sequential fetching
    localparam logic [0:0] ST_PEND = 1'b1;  // redirect waiting for a miss to end

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_buf.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_buf
//  Purpose  : Small in-order FIFO of fetched {pc, instr} pairs. The head is
//             held in its own register so it keeps its last value while the
//             FIFO is empty (including after a flush).
//  Ports    : clk, rst        - clock, async active-high reset
//             flush           - drop all entries, reset pointers
//             push, push_data - write one entry (ignored when full)
//             pop             - remove head entry (ignored when empty)
//             head_data       - current head entry
//             empty, full     - occupancy flags
//             count           - number of valid entries
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_buf #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_head;

    logic             w_push_ok;
    logic             w_pop_ok;
    logic [PTR_W-1:0] w_rptr_inc;
    logic             w_head_ld;
    logic [WIDTH-1:0] w_head_nxt;

    assign empty      = (r_count == '0);
    assign full       = (r_count == CNT_W'(DEPTH));
    assign count      = r_count;
    assign head_data  = r_head;
    assign w_push_ok  = push & ~full;
    assign w_pop_ok   = pop & ~empty;
    assign w_rptr_inc = r_rptr + PTR_W'(1);

    // Work out what the head will be after this edge, so the head register
    // only changes when a valid entry will sit at the front.
    always_comb begin
        w_head_ld  = 1'b0;
        w_head_nxt = r_head;
        if (!flush) begin
            if (w_pop_ok) begin
                if (r_count > CNT_W'(1)) begin
                    w_head_ld  = 1'b1;
                    w_head_nxt = r_mem[w_rptr_inc];
                end else if (w_push_ok) begin
                    w_head_ld  = 1'b1;
                    w_head_nxt = push_data;
                end
            end else if (empty && w_push_ok) begin
                w_head_ld  = 1'b1;
                w_head_nxt = push_data;
            end
        end
    end

    // Storage needs no reset: nothing is read before it is written.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_head  <= '0;
        end else begin
            if (w_head_ld) begin
                r_head <= w_head_nxt;
            end
            if (flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push_ok) begin
                    r_wptr <= r_wptr + PTR_W'(1);
                end
                if (w_pop_ok) begin
                    r_rptr <= w_rptr_inc;
                end
                case ({w_push_ok, w_pop_ok})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule : fetch_buf
`default_nettype wire

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pc_unit
//  Purpose  : Generates the sequential fetch pc, holds it across cache
//             stalls, buffers returned instructions for decode and handles
//             branch/jump redirects (flushing buffered work).
//  Ports    : clk, rst                    - clock, async active-high reset
//             redirect_valid, redirect_pc - redirect request and target
//             pc                          - registered fetch address
//             instr, stall                - cache response / miss indication
//             out_valid, out_pc,
//             out_instr, out_ready        - decode handshake
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                BUF_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] pc,
    input  logic [DATA_W-1:0] instr,
    input  logic              stall,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_instr,
    input  logic              out_ready
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    logic [ADDR_W-1:0]        r_pc;
    logic [0:0]               r_state;
    logic [ADDR_W-1:0]        r_pend_pc;

    logic [ADDR_W-1:0]        w_redir_pc;
    logic [ADDR_W-1:0]        w_pend_target;
    logic                     w_accept;
    logic                     w_pop;
    logic                     w_empty;
    logic                     w_full;
    logic [CNT_W-1:0]         w_count;
    logic [ADDR_W+DATA_W-1:0] w_head;
    logic                     w_unused_full;

    assign w_redir_pc    = redirect_pc & ~ADDR_W'(ALIGN_MASK);
    // A redirect arriving in the same cycle the miss ends is the newest target.
    assign w_pend_target = redirect_valid ? w_redir_pc : r_pend_pc;
    assign w_accept      = (r_state == ST_RUN) & ~stall & ~redirect_valid &
                           (w_count < CNT_W'(BUF_DEPTH));
    assign w_pop         = out_valid & out_ready;
    assign w_unused_full = w_full;

    assign pc        = r_pc;
    assign out_valid = ~w_empty;
    assign out_pc    = w_head[ADDR_W+DATA_W-1:DATA_W];
    assign out_instr = w_head[DATA_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_state   <= ST_RUN;
            r_pend_pc <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (redirect_valid) begin
                        // During a miss the pc must stay put, so park the target.
                        if (stall) begin
                            r_pend_pc <= w_redir_pc;
                            r_state   <= ST_PEND;
                        end else begin
                            r_pc <= w_redir_pc;
                        end
                    end else if (w_accept) begin
                        r_pc <= r_pc + ADDR_W'(INSTR_BYTES);
                    end
                end
                ST_PEND: begin
                    if (redirect_valid) begin
                        r_pend_pc <= w_redir_pc;
                    end
                    if (!stall) begin
                        r_pc    <= w_pend_target;
                        r_state <= ST_RUN;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    fetch_buf #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (w_accept),
        .push_data ({r_pc, instr}),
        .pop       (w_pop),
        .head_data (w_head),
        .empty     (w_empty),
        .full      (w_full),
        .count     (w_count)
    );

endmodule : fetch_pc_unit
`default_nettype wire

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Upstream fetch stage of the instruction cache: generates the sequential fetch address `pc` and holds it while the cache asserts `stall`.
- Captures each returned {pc, instr} pair into a small in-order buffer and presents it to decode with a valid/ready handshake.
- Accepts branch/jump redirects, which flush buffered instructions.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset (bits [1:0] must be 0)
- ADDR_W, 32, address width
- DATA_W, 32, instruction width
- BUF_DEPTH, 2, output buffer entries (power of two, >=2)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- redirect_valid  input  1  decode/execute requests fetch from redirect_pc
- redirect_pc  input  ADDR_W  redirect target; bits [1:0] ignored (forced 0)
- pc  output  ADDR_W  fetch address to cache, registered
- instr  input  DATA_W  cache read data for current pc
- stall  input  1  cache miss in progress; instr invalid, pc must stay stable
- out_valid  output  1  buffer head holds a valid instruction
- out_pc  output  ADDR_W  address of head instruction
- out_instr  output  DATA_W  head instruction
- out_ready  input  1  decode accepts head this cycle

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC, state=RUN, buffer empty, out_valid=0, out_pc=0, out_instr=0, pend_pc=0.
- Cache contract: in any cycle with stall=0, instr is the word at the pc presented that cycle (0-cycle hit). No capture is performed while stall=1.
- accept = (state==RUN) & ~stall & ~redirect_valid & (count<BUF_DEPTH), using the registered count. No same-cycle pass-through when the buffer is full.
- On accept: push {pc, instr}; pc <= pc+4. Modulo 2^ADDR_W, so 32'hFFFF_FFFC -> 32'h0000_0000.
- pop = out_valid & out_ready. Push and pop in the same cycle are both performed; count is unchanged.
- States:
  - RUN:
    - stall=1 & redirect_valid: pend_pc <= {redirect_pc[ADDR_W-1:2],2'b00}; flush buffer; -> PEND. pc is held.
    - stall=0 & redirect_valid: flush buffer; pc <= aligned redirect_pc; the current response is discarded; stay in RUN.
    - Otherwise: normal accept/hold.
  - PEND:
    - pc is held; nothing is pushed.
    - A further redirect_valid overwrites pend_pc; the newest target wins.
    - When stall=0: pc <= pend_pc; the response for the old pc is discarded; -> RUN.
- Flush: count<=0 and read/write pointers reset in the same edge. out_valid is 0 the following cycle. A pop in the same cycle as a flush is still a completed transfer for decode.
- Buffer full, stall=0: pc is held and the cache re-reads the same word; no duplicate entry is pushed.
- pc changes only on accept, on a redirect, or on the PEND->RUN exit. It never changes while stall=1.
- out_pc/out_instr come from the head entry register and keep their last value when out_valid=0 (not cleared except by reset).
- Ordering: instructions leave in strictly increasing pc order, except after a redirect. No instruction fetched before a redirect is output after it.

Decomposition:
- Shared package fetch_pkg:
  - INSTR_BYTES=4
  - state encoding ST_RUN / ST_PEND
  - ALIGN_MASK constant
- Sub-module fetch_buf: parametric synchronous FIFO. Ports: clk, rst, flush, push, push_data {pc, instr}, pop, head data, empty, full, count.
- fetch_pc_unit holds the pc register, the FSM and pend_pc.

Test Plan:
- Reset, stall=0, out_ready=1, cache returns instr=pc^32'hA5A5_0000 → pc sequence 0,4,8,C. out_valid rises the cycle after the first accept. out_pc/out_instr = (0, 32'hA5A5_0000), then (4, 32'hA5A5_0004), and so on.
- stall high 5 cycles while pc=0x10 → pc stays 0x10 all 5 cycles; no push. After stall falls, 0x10 is captured once and pc becomes 0x14.
- out_ready=0 for 6 cycles, stall=0 → exactly 2 entries (0x0, 0x4) buffered and pc holds at 0x8. Raising out_ready drains 0x0, 0x4, 0x8 in order with no duplicates.
- redirect_valid with redirect_pc=0x103, stall=0, buffer holding 2 entries → out_valid=0 next cycle, pc=0x100. The next output is out_pc=0x100.
- During stall at pc=0x20, redirect 0x200 then 0x300 on later cycles → pc stays 0x20 until stall falls, then pc=0x300. The word for 0x20 is never output.
- pc=0xFFFF_FFF8, free run → outputs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000. Async rst asserted mid-PEND → outputs reset immediately, and pc=RESET_PC after release.
